// File: rtl/cpu_ce_governor.sv
// Multi-channel CPU clock-enable generator: fractional base ticks, deferred catch-up
// enables for ticks lost to ROM stalls, and a frame-synchronised pause FSM gating all channels.
module cpu_ce_governor #(
  parameter int unsigned NUM_CH     = 2,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned MAX_DEFER  = 2**CNT_W-1,
  parameter bit          SYNC_PAUSE = 1'b1
) (
  input  logic                 clk_sys,
  input  logic                 reset,
  input  logic [NUM_CH*10-1:0] frac_n,
  input  logic [NUM_CH*10-1:0] frac_m,
  input  logic [NUM_CH-1:0]    stall,
  input  logic [NUM_CH-1:0]    turbo,
  input  logic                 pause_rq,
  input  logic                 vsync,
  output logic [NUM_CH-1:0]    ce_base,
  output logic [NUM_CH-1:0]    ce_half,
  output logic [NUM_CH-1:0]    ce_out,
  output logic                 paused,
  output logic [NUM_CH-1:0]    defer_ovf
);

  typedef enum logic [1:0] {StRun, StPendPause, StPaused, StPendResume} state_e;

  localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(MAX_DEFER);

  logic [9:0]       acc_q [NUM_CH];
  logic [9:0]       acc_d [NUM_CH];
  logic [10:0]      sum   [NUM_CH];
  logic [CNT_W-1:0] cnt_q [NUM_CH];
  logic [CNT_W-1:0] cnt_d [NUM_CH];
  logic [NUM_CH-1:0] base_q, base_d, tog_q, tog_d, ovf_q, ovf_d;
  logic [NUM_CH-1:0] inc, dec;
  state_e state_q, state_d;
  logic   vsync_q, vs_rise;
  logic   paused_q, paused_d;
  logic   run_g;

  assign run_g = ~paused_q;

  // Fractional divider; m=0 falls out naturally since sum >= 0 always ticks.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      sum[i]    = {1'b0, acc_q[i]} + {1'b0, frac_n[10*i +: 10]};
      acc_d[i]  = sum[i][9:0];
      base_d[i] = 1'b0;
      if (sum[i] >= {1'b0, frac_m[10*i +: 10]}) begin
        acc_d[i]  = 10'(sum[i] - {1'b0, frac_m[10*i +: 10]});
        base_d[i] = 1'b1;
      end
    end
  end

  assign tog_d = tog_q ^ base_q;

  // Deferred-tick bank: a lost tick adds credit, a free unstalled cycle spends one.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      inc[i]    = run_g & base_q[i] & stall[i];
      dec[i]    = run_g & ~base_q[i] & ~stall[i] & (cnt_q[i] != '0);
      cnt_d[i]  = cnt_q[i];
      ovf_d[i]  = ovf_q[i];
      ce_out[i] = run_g & ~stall[i] & (base_q[i] | turbo[i] | (cnt_q[i] != '0));
      if (inc[i]) begin
        if (cnt_q[i] == MaxCnt) ovf_d[i] = 1'b1;
        else                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end else if (dec[i]) begin
        cnt_d[i] = cnt_q[i] - CNT_W'(1);
      end
    end
  end

  assign vs_rise = vsync & ~vsync_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      StRun:        if (pause_rq) state_d = StPendPause;
      StPendPause:  if (!pause_rq) state_d = StRun;
                    else if (vs_rise || !SYNC_PAUSE) state_d = StPaused;
      StPaused:     if (!pause_rq) state_d = StPendResume;
      StPendResume: if (pause_rq) state_d = StPaused;
                    else if (vs_rise || !SYNC_PAUSE) state_d = StRun;
      default:      state_d = StRun;
    endcase
    paused_d = (state_d == StPaused) || (state_d == StPendResume);
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        acc_q[i] <= '0;
        cnt_q[i] <= '0;
      end
      base_q   <= '0;
      tog_q    <= '0;
      ovf_q    <= '0;
      state_q  <= StRun;
      vsync_q  <= 1'b0;
      paused_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        acc_q[i] <= acc_d[i];
        cnt_q[i] <= cnt_d[i];
      end
      base_q   <= base_d;
      tog_q    <= tog_d;
      ovf_q    <= ovf_d;
      state_q  <= state_d;
      vsync_q  <= vsync;
      paused_q <= paused_d;
    end
  end

  assign ce_base   = base_q;
  assign ce_half   = base_q & tog_q;
  assign paused    = paused_q;
  assign defer_ovf = ovf_q;

endmodule

// File: tb/tb_cpu_ce_governor.sv
// Bench for cpu_ce_governor: cycle scoreboard against a behavioural model plus
// directed counts for ticks, catch-up credit, saturation, pause timing and reset.
module tb_cpu_ce_governor;

  localparam int MAXD = 7;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic [19:0] frac_n, frac_m;
  logic [1:0]  stall, turbo;
  logic        pause_rq, vsync;
  logic [1:0]  ce_base, ce_half, ce_out, defer_ovf;
  logic        paused;
  logic [1:0]  ce_base_a, ce_half_a, ce_out_a, defer_ovf_a;
  logic        paused_a;

  always #5 clk_sys = ~clk_sys;

  cpu_ce_governor #(.NUM_CH(2), .CNT_W(3), .SYNC_PAUSE(1'b1)) dut (
    .clk_sys(clk_sys), .reset(reset), .frac_n(frac_n), .frac_m(frac_m), .stall(stall),
    .turbo(turbo), .pause_rq(pause_rq), .vsync(vsync), .ce_base(ce_base), .ce_half(ce_half),
    .ce_out(ce_out), .paused(paused), .defer_ovf(defer_ovf)
  );

  cpu_ce_governor #(.NUM_CH(2), .CNT_W(3), .SYNC_PAUSE(1'b0)) dut_a (
    .clk_sys(clk_sys), .reset(reset), .frac_n(frac_n), .frac_m(frac_m), .stall(stall),
    .turbo(turbo), .pause_rq(pause_rq), .vsync(vsync), .ce_base(ce_base_a),
    .ce_half(ce_half_a), .ce_out(ce_out_a), .paused(paused_a), .defer_ovf(defer_ovf_a)
  );

  int total = 0, bad = 0;
  int cyc = 0;
  int n_base[2], n_half[2], n_out[2];
  int n_paused, turbo_bad;
  int rise_main, fall_main, rise_a, fall_a;
  bit prev_p, prev_pa;
  logic [1:0] last_out, last_ovf;
  logic [8:0] exp_q[$];

  // Reference model state (main instance, synchronous pause)
  int m_acc[2], m_cnt[2];
  bit m_base[2], m_tog[2], m_ovf[2];
  int m_st;
  bit m_vs_d, m_paused;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_update();
    int sum, nn, mm, nxt;
    bit g, inc, dec, vs_rise;
    if (reset) begin
      for (int c = 0; c < 2; c++) begin
        m_acc[c] = 0; m_cnt[c] = 0; m_base[c] = 0; m_tog[c] = 0; m_ovf[c] = 0;
      end
      m_st = 0; m_vs_d = 0; m_paused = 0;
      return;
    end
    g = !m_paused;
    for (int c = 0; c < 2; c++) begin
      nn  = int'(frac_n[c*10 +: 10]);
      mm  = int'(frac_m[c*10 +: 10]);
      inc = g && m_base[c] && stall[c];
      dec = g && !m_base[c] && !stall[c] && (m_cnt[c] != 0);
      if (inc) begin
        if (m_cnt[c] == MAXD) m_ovf[c] = 1;
        else m_cnt[c]++;
      end
      if (dec) m_cnt[c]--;
      m_tog[c] ^= m_base[c];
      sum = m_acc[c] + nn;
      if (sum >= mm) begin
        m_acc[c] = (sum - mm) % 1024;
        m_base[c] = 1;
      end else begin
        m_acc[c] = sum;
        m_base[c] = 0;
      end
    end
    vs_rise = vsync && !m_vs_d;
    nxt = m_st;
    case (m_st)
      0: if (pause_rq) nxt = 1;
      1: if (!pause_rq) nxt = 0; else if (vs_rise) nxt = 2;
      2: if (!pause_rq) nxt = 3;
      default: if (pause_rq) nxt = 2; else if (vs_rise) nxt = 0;
    endcase
    m_st = nxt;
    m_paused = (nxt >= 2);
    m_vs_d = vsync;
  endtask

  // One clk_sys cycle: push expectation, compare at negedge, advance model at posedge.
  task automatic step();
    logic [8:0] e, got;
    bit o[2];
    for (int c = 0; c < 2; c++)
      o[c] = !m_paused && !stall[c] && (m_base[c] || turbo[c] || (m_cnt[c] != 0));
    e = {m_paused, m_ovf[1], m_ovf[0], o[1], o[0], m_base[1] & m_tog[1], m_base[0] & m_tog[0],
         m_base[1], m_base[0]};
    exp_q.push_back(e);
    @(negedge clk_sys);
    got = {paused, defer_ovf, ce_out, ce_half, ce_base};
    check_eq($sformatf("cyc%0d", cyc), 32'(got), 32'(exp_q.pop_front()));
    for (int c = 0; c < 2; c++) begin
      n_base[c] += int'(ce_base[c]);
      n_half[c] += int'(ce_half[c]);
      n_out[c]  += int'(ce_out[c]);
    end
    n_paused += int'(paused);
    if (paused && !prev_p) rise_main = cyc;
    if (!paused && prev_p) fall_main = cyc;
    if (paused_a && !prev_pa) rise_a = cyc;
    if (!paused_a && prev_pa) fall_a = cyc;
    prev_p = paused;
    prev_pa = paused_a;
    if (ce_out[1] !== ~stall[1]) turbo_bad++;
    last_out = ce_out;
    last_ovf = defer_ovf;
    @(posedge clk_sys);
    model_update();
    #1;
    cyc++;
  endtask

  task automatic clr_counts();
    for (int c = 0; c < 2; c++) begin
      n_base[c] = 0; n_half[c] = 0; n_out[c] = 0;
    end
    n_paused = 0;
    turbo_bad = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  int s, v, d, w;

  initial begin
    reset = 1'b1; frac_n = '0; frac_m = {10'd1, 10'd1}; stall = '0; turbo = '0;
    pause_rq = 1'b0; vsync = 1'b0;
    repeat (2) @(posedge clk_sys);
    model_update();
    #1;
    step();
    check_eq("reset_outs", 32'({ce_base, ce_half, ce_out, paused, defer_ovf}), 32'd0);
    reset = 1'b0;

    // n=9/m=20, no stall: 90 ticks in 200 edges (first sample shows post-reset zeros)
    frac_n = {10'd9, 10'd9}; frac_m = {10'd20, 10'd20};
    clr_counts();
    run(201);
    check_eq("base_9_20", n_base[0], 90);
    check_eq("half_9_20", n_half[0], 45);
    check_eq("out_9_20", n_out[0], 90);
    check_eq("base1_9_20", n_base[1], 90);

    // Catch-up: 5 lost ticks replayed as 5 extra enables; ch1 n=0 never ticks
    do_reset();
    frac_n = {10'd0, 10'd1}; frac_m = {10'd4, 10'd4}; stall = 2'b01;
    clr_counts();
    run(22);
    check_eq("stall_out", n_out[0], 0);
    check_eq("stall_base", n_base[0], 5);
    stall = 2'b00;
    clr_counts();
    run(40);
    check_eq("catchup_extra", n_out[0] - n_base[0], 5);
    check_eq("n0_no_ticks", n_base[1], 0);

    // Saturation at 7 with 9 lost ticks; ch1 m=0 ticks every cycle
    do_reset();
    frac_n = {10'd5, 10'd1}; frac_m = {10'd0, 10'd4}; stall = 2'b01;
    clr_counts();
    for (int k = 1; k <= 38; k++) begin
      step();
      if (k == 33) check_eq("ovf_before", 32'(last_ovf[0]), 32'd0);
      if (k == 34) check_eq("ovf_after", 32'(last_ovf[0]), 32'd1);
    end
    check_eq("sat_base", n_base[0], 9);
    check_eq("m0_every", n_base[1], 37);
    stall = 2'b00;
    clr_counts();
    run(40);
    check_eq("sat_extra", n_out[0] - n_base[0], 7);
    check_eq("ovf_sticky", 32'(last_ovf[0]), 32'd1);
    do_reset();
    step();
    check_eq("ovf_cleared", 32'(last_ovf[0]), 32'd0);

    // Pause entry/exit on vsync rise; the async instance follows 2 cycles after the request
    do_reset();
    frac_n = {10'd3, 10'd1}; frac_m = {10'd7, 10'd4};
    run(5);
    s = cyc; pause_rq = 1'b1;
    run(6);
    v = cyc; vsync = 1'b1;
    run(3);
    vsync = 1'b0;
    clr_counts();
    run(8);
    check_eq("paused_no_ce", n_out[0] + n_out[1], 0);
    check_eq("paused_held", n_paused, 8);
    d = cyc; pause_rq = 1'b0;
    run(5);
    w = cyc; vsync = 1'b1;
    run(3);
    vsync = 1'b0;
    run(2);
    check_eq("pause_rise", rise_main - v, 1);
    check_eq("pause_fall", fall_main - w, 1);
    check_eq("async_rise", rise_a - s, 2);
    check_eq("async_fall", fall_a - d, 2);

    // Short request withdrawn before vsync never pauses
    do_reset();
    clr_counts();
    pause_rq = 1'b1;
    step();
    pause_rq = 1'b0;
    run(6);
    vsync = 1'b1;
    run(3);
    vsync = 1'b0;
    run(2);
    check_eq("pulse_no_pause", n_paused, 0);

    // Turbo follows ~stall; reset with banked credit discards it
    do_reset();
    frac_n = {10'd1, 10'd1}; frac_m = {10'd8, 10'd4}; turbo = 2'b10;
    clr_counts();
    for (int j = 0; j < 18; j++) begin
      stall = {1'((j / 3) % 2), 1'b1};
      step();
    end
    check_eq("turbo_follow", turbo_bad, 0);
    stall = 2'b00;
    do_reset();
    step();
    check_eq("rst_ce_out", 32'(last_out[0]), 32'd0);
    clr_counts();
    run(20);
    check_eq("rst_no_credit", n_out[0], n_base[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
